// File: rtl/exec_cdb_cluster_if.sv
// exec_cdb_cluster_if: issue-side ops in, CDB broadcasts out.
// master = issue queue / snoopers, slave = execution cluster.
interface exec_cdb_cluster_if #(
  parameter int ISSUE_PORTS = 3,
  parameter int REG_SIZE    = 32,
  parameter int NUM_TAGS    = 64,
  parameter int ROB_SIZE    = 64
);
  localparam int TW = $clog2(NUM_TAGS);
  localparam int RW = $clog2(ROB_SIZE);

  logic [ISSUE_PORTS-1:0][3:0]          fu_op;
  logic [ISSUE_PORTS-1:0][REG_SIZE-1:0] fu_rs1;
  logic [ISSUE_PORTS-1:0][REG_SIZE-1:0] fu_rs2;
  logic [ISSUE_PORTS-1:0][TW-1:0]       fu_tags;
  logic [ISSUE_PORTS-1:0][RW-1:0]       fu_rob_index;
  logic [ISSUE_PORTS-1:0]               fu_valid;
  logic [ISSUE_PORTS-1:0]               fu_ready;

  logic [ISSUE_PORTS-1:0][TW-1:0]       cdb_tags;
  logic [ISSUE_PORTS-1:0][REG_SIZE-1:0] cdb_data;
  logic [ISSUE_PORTS-1:0][RW-1:0]       cdb_rob_index;
  logic [ISSUE_PORTS-1:0]               cdb_valid;

  modport master (
    output fu_op, fu_rs1, fu_rs2, fu_tags,
    output fu_rob_index, fu_valid,
    input  fu_ready,
    input  cdb_tags, cdb_data, cdb_rob_index,
    input  cdb_valid
  );

  modport slave (
    input  fu_op, fu_rs1, fu_rs2, fu_tags,
    input  fu_rob_index, fu_valid,
    output fu_ready,
    output cdb_tags, cdb_data, cdb_rob_index,
    output cdb_valid
  );
endinterface

// File: rtl/exec_cdb_cluster.sv
// exec_cdb_cluster: per-lane ALU + pipelined MUL feeding
// a small result FIFO that drains onto the CDB every cycle.
module exec_cdb_cluster #(
  parameter int ISSUE_PORTS = 3,
  parameter int REG_SIZE    = 32,
  parameter int NUM_TAGS    = 64,
  parameter int ROB_SIZE    = 64,
  parameter int MUL_LAT     = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  exec_cdb_cluster_if.slave bus,
  output logic              overflow_err
);
  localparam int TW = $clog2(NUM_TAGS);
  localparam int RW = $clog2(ROB_SIZE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NS = MUL_LAT - 1;
  localparam int OW = $clog2(FIFO_DEPTH + MUL_LAT) + 1;

  typedef struct packed {
    logic [TW-1:0]       tag;
    logic [RW-1:0]       rob;
    logic [REG_SIZE-1:0] data;
  } ent_t;

  function automatic logic [REG_SIZE-1:0] alu(
    input logic [3:0]          op,
    input logic [REG_SIZE-1:0] a,
    input logic [REG_SIZE-1:0] b
  );
    logic [4:0]          sh;
    logic [REG_SIZE-1:0] r;
    sh = b[4:0];
    r  = '0;
    unique case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a << sh;
      4'd3:    r = REG_SIZE'($signed(a) < $signed(b));
      4'd4:    r = REG_SIZE'(a < b);
      4'd5:    r = a ^ b;
      4'd6:    r = a >> sh;
      4'd7:    r = $signed(a) >>> sh;
      4'd8:    r = a | b;
      4'd9:    r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [ISSUE_PORTS-1:0] viol;
  logic                   err_q, err_d;

  for (genvar l = 0; l < ISSUE_PORTS; l++) begin : g_lane
    ent_t          mem_q [FIFO_DEPTH];
    ent_t          mul_q [NS];
    logic [NS-1:0] mv_q;
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] infl, occ;
    logic          rdy, acc, is_mul;
    logic          alu_push, mul_push, pop;
    ent_t          alu_e, mul_e, head;

    // Occupancy = queued results plus multiplies still in flight.
    always_comb begin
      infl = '0;
      for (int k = 0; k < NS; k++) begin
        infl = infl + OW'(mv_q[k]);
      end
      occ = OW'(cnt_q) + infl;
      rdy = occ <= OW'(FIFO_DEPTH - 2);
    end

    assign is_mul   = bus.fu_op[l] == 4'd10;
    assign acc      = bus.fu_valid[l] & rdy;
    assign viol[l]  = bus.fu_valid[l] & ~rdy;
    assign alu_push = acc & ~is_mul;
    assign mul_push = mv_q[NS-1];
    assign pop      = cnt_q != '0;
    assign cnt_d    = cnt_q + CW'(alu_push)
                    + CW'(mul_push) - CW'(pop);

    assign alu_e.tag  = bus.fu_tags[l];
    assign alu_e.rob  = bus.fu_rob_index[l];
    assign alu_e.data = alu(bus.fu_op[l],
                            bus.fu_rs1[l],
                            bus.fu_rs2[l]);
    assign mul_e.tag  = bus.fu_tags[l];
    assign mul_e.rob  = bus.fu_rob_index[l];
    assign mul_e.data = bus.fu_rs1[l] * bus.fu_rs2[l];

    assign head = mem_q[rd_q];

    assign bus.fu_ready[l]      = rdy;
    assign bus.cdb_valid[l]     = pop;
    assign bus.cdb_tags[l]      = pop ? head.tag  : '0;
    assign bus.cdb_rob_index[l] = pop ? head.rob  : '0;
    assign bus.cdb_data[l]      = pop ? head.data : '0;

    // Multiplier pipe: product formed on entry, carried to completion.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mv_q <= '0;
        for (int k = 0; k < NS; k++) mul_q[k] <= '0;
      end else begin
        mv_q[0]  <= acc & is_mul;
        mul_q[0] <= mul_e;
        for (int k = 1; k < NS; k++) begin
          mv_q[k]  <= mv_q[k-1];
          mul_q[k] <= mul_q[k-1];
        end
      end
    end

    // Result FIFO: a finishing MUL lands ahead of a same-edge ALU op.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
        for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
      end else begin
        if (mul_push) mem_q[wr_q] <= mul_q[NS-1];
        if (alu_push) mem_q[wr_q + PW'(mul_push)] <= alu_e;
        wr_q  <= wr_q + PW'(mul_push) + PW'(alu_push);
        rd_q  <= rd_q + PW'(pop);
        cnt_q <= cnt_d;
      end
    end
  end

  assign err_d        = err_q | (|viol);
  assign overflow_err = err_q;

  // Sticky flag for any op offered to a lane that was not ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
endmodule

// File: tb/tb_exec_cdb_cluster.sv
// tb_exec_cdb_cluster: scoreboard bench, per-lane expected
// results retimed through an ideal one-pop-per-cycle queue.
module tb_exec_cdb_cluster;
  localparam int P       = 3;
  localparam int MUL_LAT = 3;
  localparam int DEPTH   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic overflow_err;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  typedef struct {
    int          lane;
    int          earl;
    int          due;
    logic [5:0]  tag;
    logic [5:0]  rob;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   last_bc[P];

  exec_cdb_cluster_if #(
    .ISSUE_PORTS(P), .REG_SIZE(32),
    .NUM_TAGS(64), .ROB_SIZE(64)
  ) bus ();

  exec_cdb_cluster #(
    .ISSUE_PORTS(P), .REG_SIZE(32),
    .NUM_TAGS(64), .ROB_SIZE(64),
    .MUL_LAT(MUL_LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [4:0] s;
    logic signed [63:0] p;
    s = b[4:0];
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << s;
      4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> s;
      4'd7: return 32'($signed(a) >>> s);
      4'd8: return a | b;
      4'd9: return a & b;
      4'd10: begin
        p = $signed(a) * $signed(b);
        return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  // One pop per cycle: each entry leaves at max(earliest, prev+1).
  function automatic void retime(input int l);
    int prev;
    prev = last_bc[l];
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].lane == l) begin
        sb[i].due = (sb[i].earl > prev + 1) ? sb[i].earl : prev + 1;
        prev = sb[i].due;
      end
    end
  endfunction

  task automatic sb_add(input int l, input int earl,
                        input logic [5:0] tag,
                        input logic [5:0] rob,
                        input logic [31:0] d);
    exp_t e;
    int   pos;
    e.lane = l;
    e.earl = earl;
    e.due  = 0;
    e.tag  = tag;
    e.rob  = rob;
    e.data = d;
    pos = sb.size();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].lane == l) begin
        if (sb[i].earl <= earl) break;
        pos = i;
      end
    end
    sb.insert(pos, e);
    retime(l);
  endtask

  task automatic issue(input int l, input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [5:0] tag,
                       input logic [5:0] rob);
    bus.fu_op[l]        = op;
    bus.fu_rs1[l]       = a;
    bus.fu_rs2[l]       = b;
    bus.fu_tags[l]      = tag;
    bus.fu_rob_index[l] = rob;
    bus.fu_valid[l]     = 1'b1;
    if (bus.fu_ready[l])
      sb_add(l, (op == 4'd10) ? cyc + MUL_LAT : cyc + 1,
             tag, rob, model(op, a, b));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    bus.fu_valid = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compare every lane of the CDB mid-cycle.
  always @(negedge clk) begin : mon
    int   idx;
    logic ev;
    if (rst_n) begin
      for (int l = 0; l < P; l++) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].lane == l) begin
            idx = i;
            break;
          end
        end
        ev = (idx >= 0) && (sb[idx].due == cyc);
        chk($sformatf("valid%0d", l),
            64'(bus.cdb_valid[l]), 64'(ev));
        if (ev) begin
          chk($sformatf("tag%0d", l),
              64'(bus.cdb_tags[l]), 64'(sb[idx].tag));
          chk($sformatf("rob%0d", l),
              64'(bus.cdb_rob_index[l]), 64'(sb[idx].rob));
          chk($sformatf("data%0d", l),
              64'(bus.cdb_data[l]), 64'(sb[idx].data));
          last_bc[l] = cyc;
          sb.delete(idx);
        end else begin
          chk($sformatf("idle%0d", l),
              64'({bus.cdb_tags[l], bus.cdb_rob_index[l],
                   bus.cdb_data[l]}), 64'd0);
        end
      end
    end
  end

  initial begin : drv
    int first_nr;
    logic vdone;
    bus.fu_valid     = '0;
    bus.fu_op        = '0;
    bus.fu_rs1       = '0;
    bus.fu_rs2       = '0;
    bus.fu_tags      = '0;
    bus.fu_rob_index = '0;
    for (int l = 0; l < P; l++) last_bc[l] = 0;

    #3;
    chk("rst_valid", 64'(bus.cdb_valid), 64'd0);
    chk("rst_ready", 64'(bus.fu_ready), 64'h7);
    chk("rst_data", 64'(bus.cdb_data[0]), 64'd0);
    chk("rst_ovf", 64'(overflow_err), 64'd0);
    #9 rst_n = 1'b1;
    step();
    idle(2);

    issue(0, 4'd0, 32'd5, 32'd7, 6'd3, 6'd9);
    step();
    issue(2, 4'd7, 32'h8000_0000, 32'd36, 6'd1, 6'd1);
    step();
    issue(2, 4'd4, 32'd1, 32'hFFFF_FFFF, 6'd2, 6'd2);
    step();
    issue(2, 4'd3, 32'd1, 32'hFFFF_FFFF, 6'd4, 6'd3);
    step();
    idle(3);

    issue(1, 4'd10, 32'd6, 32'd7, 6'd5, 6'd10);
    step();
    step();
    issue(1, 4'd0, 32'd1, 32'd1, 6'd6, 6'd11);
    step();
    idle(4);

    issue(0, 4'd0, 32'd10, 32'd1, 6'd7, 6'd20);
    issue(1, 4'd0, 32'd20, 32'd2, 6'd8, 6'd21);
    issue(2, 4'd0, 32'd30, 32'd3, 6'd0, 6'd22);
    step();
    idle(3);

    for (int c = 0; c < 200; c++) begin
      for (int l = 0; l < P; l++) begin
        if ($urandom_range(0, 3) != 0 && bus.fu_ready[l])
          issue(l, 4'($urandom_range(0, 15)),
                $urandom, $urandom,
                6'($urandom_range(0, 63)),
                6'($urandom_range(0, 63)));
      end
      step();
    end
    idle(8);
    chk("ovf_clean", 64'(overflow_err), 64'd0);

    first_nr = -1;
    vdone = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.fu_ready[0]) begin
        issue(0, 4'd10, 32'(i + 3), 32'(i + 5),
              6'(10 + i), 6'(i));
      end else begin
        if (first_nr < 0) first_nr = i;
        if (!vdone) begin
          issue(0, 4'd10, 32'd9, 32'd9, 6'd63, 6'd63);
          vdone = 1'b1;
        end
      end
      step();
    end
    chk("ready_drop", 64'(first_nr), 64'd3);
    chk("ovf_set", 64'(overflow_err), 64'd1);
    idle(8);

    issue(0, 4'd10, 32'd2, 32'd3, 6'd20, 6'd30);
    step();
    issue(0, 4'd10, 32'd4, 32'd5, 6'd21, 6'd31);
    step();
    issue(0, 4'd10, 32'd6, 32'd7, 6'd22, 6'd32);
    step();
    chk("pre_rst_valid", 64'(bus.cdb_valid[0]), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.cdb_valid), 64'd0);
    chk("mid_rst_tag", 64'(bus.cdb_tags[0]), 64'd0);
    chk("mid_rst_ready", 64'(bus.fu_ready), 64'h7);
    chk("mid_rst_ovf", 64'(overflow_err), 64'd0);
    sb.delete();
    for (int l = 0; l < P; l++) last_bc[l] = cyc;
    #1 rst_n = 1'b1;
    idle(10);
    chk("post_rst_ready", 64'(bus.fu_ready), 64'h7);
    chk("drain", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
